// File: rtl/hazard_pipeline_ctrl_pkg.sv
// Shared widths, pipeline-register layouts and the register-match helper
// for the hazard pipeline controller.
package pipeline_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    typedef logic [REG_W-1:0] reg_t;

    localparam reg_t              ZERO_REG = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef struct packed {
        reg_t rs;
        reg_t rt;
        reg_t wr;
        logic reg_write;
        logic mem_to_reg;
    } idex_t;

    typedef struct packed {
        reg_t wr;
        logic reg_write;
        logic mem_to_reg;
    } exmem_t;

    typedef struct packed {
        reg_t wr;
        logic reg_write;
    } memwb_t;

    localparam idex_t IDEX_BUBBLE = '0;

    // A write to $0 never creates a dependency.
    function automatic logic reg_match(input reg_t wr, input reg_t src_a, input reg_t src_b);
        return (wr != ZERO_REG) && ((wr == src_a) || (wr == src_b));
    endfunction

endpackage

// File: rtl/hazard_pipeline_ctrl_if.sv
// Bundle between the pipeline registers and the hazard detector.
// Branch/MEM-stage members exist only when BRANCH_ID_HAZARD_EN is defined.
interface hazard_pipeline_ctrl_if import pipeline_pkg::*; ();

    reg_t rs_id;
    reg_t rt_id;
    reg_t wr_e;
    logic rw_e;
    logic mtr_e;
`ifdef BRANCH_ID_HAZARD_EN
    logic branch_d;
    reg_t wr_m;
    logic mtr_m;
`endif
    logic stall;

    modport master (
        output rs_id, rt_id, wr_e, rw_e, mtr_e,
`ifdef BRANCH_ID_HAZARD_EN
        output branch_d, wr_m, mtr_m,
`endif
        input  stall
    );

    modport slave (
        input  rs_id, rt_id, wr_e, rw_e, mtr_e,
`ifdef BRANCH_ID_HAZARD_EN
        input  branch_d, wr_m, mtr_m,
`endif
        output stall
    );

endinterface

// File: rtl/hazard_pipeline_ctrl_hazard_detect.sv
// Combinational load-use / branch-in-decode hazard detector.
// Branch hazards are detected only when BRANCH_ID_HAZARD_EN is defined.
module hazard_detect import pipeline_pkg::*; (
    hazard_pipeline_ctrl_if.slave hz
);

    logic lwstall;
    logic branchstall;

    always_comb begin
        lwstall = hz.mtr_e & hz.rw_e & reg_match(hz.wr_e, hz.rs_id, hz.rt_id);
`ifdef BRANCH_ID_HAZARD_EN
        // A branch compares in decode, so it must wait for any ALU result in E
        // and for a load still in M.
        branchstall = hz.branch_d &
                      ((hz.rw_e  & reg_match(hz.wr_e, hz.rs_id, hz.rt_id)) |
                       (hz.mtr_m & reg_match(hz.wr_m, hz.rs_id, hz.rt_id)));
`else
        branchstall = 1'b0;
`endif
        hz.stall = lwstall | branchstall;
    end

endmodule

// File: rtl/hazard_pipeline_ctrl.sv
// ID/EX, EX/MEM, MEM/WB pipeline registers with hazard stall/flush and a
// saturating stall counter. Optional branch hazards: BRANCH_ID_HAZARD_EN.
module hazard_pipeline_ctrl import pipeline_pkg::*; (
    input  logic             clk,
    input  logic             reset,
    input  reg_t             Rs_ID,
    input  reg_t             Rt_ID,
    input  reg_t             writereg_D,
    input  logic             RegWrite_D,
    input  logic             MemtoReg_D,
    input  logic             Branch_D,
    output reg_t             Rs_EX,
    output reg_t             Rt_EX,
    output reg_t             writereg_E,
    output logic             RegWrite_E,
    output logic             MemtoReg_E,
    output reg_t             writereg_M,
    output logic             RegWrite_M,
    output logic             MemtoReg_M,
    output reg_t             writereg_WB,
    output logic             RegWrite_WB,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_E,
    output logic [CNT_W-1:0] stall_count
);

    idex_t            idex_q,  idex_d;
    exmem_t           exmem_q, exmem_d;
    memwb_t           memwb_q, memwb_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             stall;

    hazard_pipeline_ctrl_if hz_if ();

    assign hz_if.rs_id = Rs_ID;
    assign hz_if.rt_id = Rt_ID;
    assign hz_if.wr_e  = idex_q.wr;
    assign hz_if.rw_e  = idex_q.reg_write;
    assign hz_if.mtr_e = idex_q.mem_to_reg;
`ifdef BRANCH_ID_HAZARD_EN
    assign hz_if.branch_d = Branch_D;
    assign hz_if.wr_m     = exmem_q.wr;
    assign hz_if.mtr_m    = exmem_q.mem_to_reg;
`else
    logic unused_branch_d;
    assign unused_branch_d = Branch_D;
`endif
    assign stall = hz_if.stall;

    hazard_detect u_hazard_detect (
        .hz (hz_if)
    );

    always_comb begin
        idex_d            = IDEX_BUBBLE;
        if (!stall) begin
            idex_d.rs         = Rs_ID;
            idex_d.rt         = Rt_ID;
            idex_d.wr         = writereg_D;
            idex_d.reg_write  = RegWrite_D;
            idex_d.mem_to_reg = MemtoReg_D;
        end

        exmem_d.wr         = idex_q.wr;
        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.mem_to_reg = idex_q.mem_to_reg;

        memwb_d.wr        = exmem_q.wr;
        memwb_d.reg_write = exmem_q.reg_write;

        cnt_d = cnt_q;
        if (stall && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            cnt_q   <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Rs_EX       = idex_q.rs;
    assign Rt_EX       = idex_q.rt;
    assign writereg_E  = idex_q.wr;
    assign RegWrite_E  = idex_q.reg_write;
    assign MemtoReg_E  = idex_q.mem_to_reg;
    assign writereg_M  = exmem_q.wr;
    assign RegWrite_M  = exmem_q.reg_write;
    assign MemtoReg_M  = exmem_q.mem_to_reg;
    assign writereg_WB = memwb_q.wr;
    assign RegWrite_WB = memwb_q.reg_write;
    assign stall_F     = stall;
    assign stall_D     = stall;
    assign flush_E     = stall;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_pipeline_ctrl.sv
// Self-checking bench for hazard_pipeline_ctrl: reset, propagation, scoreboarded
// pipeline transfers, load-use, $0, branch, reset mid-stall and saturation.
module tb_hazard_pipeline_ctrl;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_t             writereg_D;
    logic             RegWrite_D, MemtoReg_D, Branch_D;
    reg_t             Rs_EX, Rt_EX, writereg_M, writereg_WB;
    logic             RegWrite_M, MemtoReg_M, RegWrite_WB;
    logic             stall_F, flush_E;
    logic [CNT_W-1:0] stall_count;

    hazard_pipeline_ctrl_if bus ();

    hazard_pipeline_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .Rs_ID       (bus.rs_id),
        .Rt_ID       (bus.rt_id),
        .writereg_D  (writereg_D),
        .RegWrite_D  (RegWrite_D),
        .MemtoReg_D  (MemtoReg_D),
        .Branch_D    (Branch_D),
        .Rs_EX       (Rs_EX),
        .Rt_EX       (Rt_EX),
        .writereg_E  (bus.wr_e),
        .RegWrite_E  (bus.rw_e),
        .MemtoReg_E  (bus.mtr_e),
        .writereg_M  (writereg_M),
        .RegWrite_M  (RegWrite_M),
        .MemtoReg_M  (MemtoReg_M),
        .writereg_WB (writereg_WB),
        .RegWrite_WB (RegWrite_WB),
        .stall_F     (stall_F),
        .stall_D     (bus.stall),
        .flush_E     (flush_E),
        .stall_count (stall_count)
    );

    typedef struct {
        reg_t rs;
        reg_t rt;
        reg_t wr;
        logic rw;
        logic mtr;
    } exp_t;

    exp_t sb_q[$];
    exp_t hist[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic drive(input reg_t rs, input reg_t rt, input reg_t wr,
                         input logic rw, input logic mtr, input logic br);
        bus.rs_id  = rs;
        bus.rt_id  = rt;
        writereg_D = wr;
        RegWrite_D = rw;
        MemtoReg_D = mtr;
        Branch_D   = br;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [48:0] all_o;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        all_o = {Rs_EX, Rt_EX, bus.wr_e, bus.rw_e, bus.mtr_e, writereg_M, RegWrite_M,
                 MemtoReg_M, writereg_WB, RegWrite_WB, stall_F, bus.stall, flush_E, stall_count};
        total_cnt++;
        if (all_o !== '0) $display("FAIL reset_state: got %h expected 0", all_o);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_propagation();
        drive(0, 0, 5, 1, 0, 0);
        step();
        total_cnt++;
        if ({bus.wr_e, bus.rw_e} !== {5'd5, 1'b1})
            $display("FAIL prop_E: got wr=%0d rw=%0b expected wr=5 rw=1", bus.wr_e, bus.rw_e);
        else pass_cnt++;
        drive(0, 0, 0, 0, 0, 0);
        step();
        total_cnt++;
        if ({writereg_M, RegWrite_M} !== {5'd5, 1'b1})
            $display("FAIL prop_M: got wr=%0d rw=%0b expected wr=5 rw=1", writereg_M, RegWrite_M);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({writereg_WB, RegWrite_WB} !== {5'd5, 1'b1})
            $display("FAIL prop_WB: got wr=%0d rw=%0b expected wr=5 rw=1", writereg_WB, RegWrite_WB);
        else pass_cnt++;
    endtask

    // Non-load traffic never stalls, so every decode word must appear in E
    // one edge later, then in M and WB on the following edges.
    task automatic test_scoreboard();
        exp_t e, got;
        hist.delete();
        for (int n = 0; n < 12; n++) begin
            e.rs  = reg_t'($urandom_range(0, 31));
            e.rt  = reg_t'($urandom_range(0, 31));
            e.wr  = reg_t'($urandom_range(0, 31));
            e.rw  = 1'($urandom_range(0, 1));
            e.mtr = 1'b0;
            drive(e.rs, e.rt, e.wr, e.rw, e.mtr, 1'b0);
            sb_q.push_back(e);
            step();
            got = sb_q.pop_front();
            hist.push_back(got);
            $display("txn %0d rs=%0d rt=%0d wr=%0d rw=%0b", n, got.rs, got.rt, got.wr, got.rw);
            total_cnt++;
            if ({Rs_EX, Rt_EX, bus.wr_e, bus.rw_e, bus.mtr_e, bus.stall} !==
                {got.rs, got.rt, got.wr, got.rw, got.mtr, 1'b0})
                $display("FAIL sb_E[%0d]: got rs=%0d rt=%0d wr=%0d rw=%0b mtr=%0b st=%0b expected rs=%0d rt=%0d wr=%0d rw=%0b mtr=0 st=0",
                         n, Rs_EX, Rt_EX, bus.wr_e, bus.rw_e, bus.mtr_e, bus.stall,
                         got.rs, got.rt, got.wr, got.rw);
            else pass_cnt++;
            if (hist.size() >= 2) begin
                total_cnt++;
                if ({writereg_M, RegWrite_M} !== {hist[hist.size()-2].wr, hist[hist.size()-2].rw})
                    $display("FAIL sb_M[%0d]: got wr=%0d rw=%0b expected wr=%0d rw=%0b", n,
                             writereg_M, RegWrite_M, hist[hist.size()-2].wr, hist[hist.size()-2].rw);
                else pass_cnt++;
            end
            if (hist.size() >= 3) begin
                total_cnt++;
                if ({writereg_WB, RegWrite_WB} !== {hist[hist.size()-3].wr, hist[hist.size()-3].rw})
                    $display("FAIL sb_WB[%0d]: got wr=%0d rw=%0b expected wr=%0d rw=%0b", n,
                             writereg_WB, RegWrite_WB, hist[hist.size()-3].wr, hist[hist.size()-3].rw);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reg0();
        drive(0, 0, 0, 1, 1, 0);
        step();
        drive(0, 0, 3, 1, 0, 0);
        #1;
        total_cnt++;
        if ({stall_F, bus.stall, flush_E} !== 3'b000)
            $display("FAIL reg0_stall: got %b expected 000", {stall_F, bus.stall, flush_E});
        else pass_cnt++;
        step();
        total_cnt++;
        if (stall_count !== exp_cnt)
            $display("FAIL reg0_count: got %0d expected %0d", stall_count, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        drive(0, 0, 8, 1, 1, 0);
        step();
        drive(8, 0, 10, 1, 0, 0);
        #1;
        total_cnt++;
        if ({stall_F, bus.stall, flush_E} !== 3'b111)
            $display("FAIL lw_stall: got %b expected 111", {stall_F, bus.stall, flush_E});
        else pass_cnt++;
        exp_cnt = exp_cnt + 1'b1;
        step();
        total_cnt++;
        if ({bus.wr_e, bus.rw_e, bus.mtr_e, bus.stall, stall_count} !== {5'd0, 1'b0, 1'b0, 1'b0, exp_cnt})
            $display("FAIL lw_bubble: got wr=%0d rw=%0b mtr=%0b st=%0b cnt=%0d expected wr=0 rw=0 mtr=0 st=0 cnt=%0d",
                     bus.wr_e, bus.rw_e, bus.mtr_e, bus.stall, stall_count, exp_cnt);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({Rs_EX, bus.wr_e, bus.rw_e} !== {5'd8, 5'd10, 1'b1})
            $display("FAIL lw_resume: got rs=%0d wr=%0d rw=%0b expected rs=8 wr=10 rw=1",
                     Rs_EX, bus.wr_e, bus.rw_e);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        logic exp_st;
`ifdef BRANCH_ID_HAZARD_EN
        exp_st = 1'b1;
`else
        exp_st = 1'b0;
`endif
        drive(0, 0, 9, 1, 0, 0);
        step();
        drive(0, 9, 0, 0, 0, 1);
        #1;
        total_cnt++;
        if (bus.stall !== exp_st)
            $display("FAIL branch_stall: got %0b expected %0b", bus.stall, exp_st);
        else pass_cnt++;
        if (exp_st) exp_cnt = exp_cnt + 1'b1;
        step();
        drive(0, 0, 0, 0, 0, 0);
        total_cnt++;
        if (stall_count !== exp_cnt)
            $display("FAIL branch_count: got %0d expected %0d", stall_count, exp_cnt);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_stall();
        logic [48:0] all_o;
        drive(0, 0, 8, 1, 1, 0);
        step();
        drive(8, 0, 12, 1, 0, 0);
        #1;
        total_cnt++;
        if (bus.stall !== 1'b1) $display("FAIL rst_pre_stall: got %0b expected 1", bus.stall);
        else pass_cnt++;
        #1;
        reset = 1'b1;
        #1;
        all_o = {Rs_EX, Rt_EX, bus.wr_e, bus.rw_e, bus.mtr_e, writereg_M, RegWrite_M,
                 MemtoReg_M, writereg_WB, RegWrite_WB, stall_F, bus.stall, flush_E, stall_count};
        total_cnt++;
        if (all_o !== '0) $display("FAIL rst_mid_stall: got %h expected 0", all_o);
        else pass_cnt++;
        exp_cnt = '0;
        #1;
        reset = 1'b0;
        step();
        total_cnt++;
        if ({Rs_EX, bus.wr_e, bus.rw_e, bus.stall, stall_count} !== {5'd8, 5'd12, 1'b1, 1'b0, 16'd0})
            $display("FAIL rst_release: got rs=%0d wr=%0d rw=%0b st=%0b cnt=%0d expected rs=8 wr=12 rw=1 st=0 cnt=0",
                     Rs_EX, bus.wr_e, bus.rw_e, bus.stall, stall_count);
        else pass_cnt++;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        force dut.stall = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        total_cnt++;
        if (stall_count !== 16'hFFFE) $display("FAIL sat_pre: got %h expected fffe", stall_count);
        else pass_cnt++;
        step();
        total_cnt++;
        if (stall_count !== 16'hFFFF) $display("FAIL sat_max: got %h expected ffff", stall_count);
        else pass_cnt++;
        repeat (5) step();
        total_cnt++;
        if (stall_count !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", stall_count);
        else pass_cnt++;
        release dut.stall;
        step();
        total_cnt++;
        if ({bus.stall, stall_count} !== {1'b0, 16'hFFFF})
            $display("FAIL sat_release: got st=%0b cnt=%h expected st=0 cnt=ffff", bus.stall, stall_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_propagation();
        test_scoreboard();
        test_reg0();
        test_load_use();
        test_branch();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_pipeline_ctrl.md
HAZARD_PIPELINE_CTRL -- requirements
Module: hazard_pipeline_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports Rs_ID and Rt_ID, input, 5 bits each: source register numbers of the instruction in decode.
REQ-004 SHALL have port writereg_D, input, 5 bits: destination register resolved in decode.
REQ-005 SHALL have ports RegWrite_D, MemtoReg_D and Branch_D, input, 1 bit each: decode control bits.
REQ-006 SHALL have ports Rs_EX, Rt_EX and writereg_E, output, 5 bits each: ID/EX register fields.
REQ-007 SHALL have ports RegWrite_E and MemtoReg_E, output, 1 bit each: ID/EX control bits.
REQ-008 SHALL have ports writereg_M, RegWrite_M and MemtoReg_M, output, 5/1/1 bits: EX/MEM fields.
REQ-009 SHALL have ports writereg_WB and RegWrite_WB, output, 5/1 bits: MEM/WB fields.
REQ-010 SHALL have ports stall_F, stall_D and flush_E, output, 1 bit each: pipeline hazard controls.
REQ-011 SHALL have port stall_count, output, 16 bits: saturating count of stall cycles.

Function
REQ-012 SHALL capture, on every clk edge, Rs_ID, Rt_ID, writereg_D, RegWrite_D and MemtoReg_D into the ID/EX fields, giving one cycle of latency.
REQ-013 SHALL, while flush_E=1, load the ID/EX register with a bubble: all 5-bit fields 0, RegWrite_E=0, MemtoReg_E=0.
REQ-014 SHALL advance E->M and M->WB unconditionally every cycle; the EX/MEM and MEM/WB registers are never stalled or flushed.
REQ-015 SHALL compute lwstall combinationally in the same cycle as: MemtoReg_E & RegWrite_E & (writereg_E!=0) & (writereg_E==Rs_ID | writereg_E==Rt_ID).
REQ-016 SHALL compute branchstall (see REQ-024) combinationally as: Branch_D & [(RegWrite_E & writereg_E!=0 & writereg_E in {Rs_ID,Rt_ID}) | (MemtoReg_M & writereg_M!=0 & writereg_M in {Rs_ID,Rt_ID})].
REQ-017 SHALL drive stall_F = stall_D = flush_E = lwstall | branchstall, with zero-cycle latency.
REQ-018 SHALL never stall on register 0, even when every other term of the condition matches.
REQ-019 SHALL guarantee that a load-use stall lasts exactly one cycle, because the inserted bubble clears MemtoReg_E.
REQ-020 SHALL increment stall_count on every clk edge where stall_D=1, holding at 16'hFFFF with no wrap-around.

Reset
REQ-021 SHALL, on assertion of reset, immediately clear all pipeline fields, control bits and stall_count to 0, independent of clk; stall_F, stall_D and flush_E consequently read 0.
REQ-022 SHALL, when reset is asserted mid-stall, abort the stall; the first edge after release captures the current decode inputs.
REQ-023 SHALL present no state-machine residue after reset; operation is determined only by the register contents.

Configuration
REQ-024 SHALL support macro BRANCH_ID_HAZARD_EN: when defined, branchstall is implemented per REQ-016; when undefined, branchstall is constant 0, Branch_D is ignored and only lwstall drives the stalls.

Structure
REQ-025 SHALL take the register-number width (5), the zero-register constant and the stall_count width (16) from the shared package pipeline_pkg.
REQ-026 SHALL place the hazard equations (REQ-015 to REQ-017) in one combinational sub-module named hazard_detect, instantiated once; the pipeline registers and the counter live in the top level.

Verification
REQ-027 SHALL cover a load-use hazard: lw into $8 (writereg_D=8, RegWrite_D=1, MemtoReg_D=1), then Rs_ID=8 -> stall_F/stall_D/flush_E=1 for exactly 1 cycle; next cycle writereg_E=0, RegWrite_E=0; stall_count=1.
REQ-028 SHALL cover register 0: lw with writereg_D=0, then Rs_ID=0 -> no stall; stall_count stays 0.
REQ-029 SHALL cover a branch hazard with BRANCH_ID_HAZARD_EN defined: add to $9 in E (RegWrite_E=1), Branch_D=1, Rt_ID=9 -> stall=1; the same stimulus with the macro undefined -> stall=0.
REQ-030 SHALL cover propagation: writereg_D=5, RegWrite_D=1 -> writereg_E=5 after 1 edge, writereg_M=5 after 2 edges, writereg_WB=5 and RegWrite_WB=1 after 3 edges.
REQ-031 SHALL cover saturation: force continuous stall conditions for 65 540 cycles -> stall_count=16'hFFFF and holds.
REQ-032 SHALL cover reset mid-stall: assert reset while stall_D=1 -> all outputs 0 before the next clk edge; stall_count=0.
